jtkunio_colmix: RTL and testbench

Colour mixer and palette stage. It sits directly downstream of the scroll, object and character tile layers. Each pixel-clock-enable it picks the visible layer by fixed priority and looks the result up in a CPU-writable 256-entry RGB444 palette RAM. It outputs blanking-aligned RGB to the video output stage.

---
 rtl/jtkunio_colmix_pkg.sv | 9 +
 rtl/jtkunio_colmix_dpram.sv | 31 +++
 rtl/jtkunio_colmix.sv | 112 +++++++++++
 tb/tb_jtkunio_colmix.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/jtkunio_colmix_pkg.sv
// Shared constants for the Kunio colour mixer: palette bank bases and pipeline depth.
package jtkunio_colmix_pkg;

    localparam logic [7:0] CHAR_BASE  = 8'h00;
    localparam logic [7:0] SCR_BASE   = 8'h40;
    localparam logic [7:0] OBJ_BASE   = 8'h80;
    localparam int         COLMIX_LAT = 2;

endpackage

// File: rtl/jtkunio_colmix_dpram.sv
// Dual-port 16-bit palette RAM: port A is a gated video read, port B is the
// CPU read/write port with per-byte write enables. Reads return pre-write data.
module jtkunio_colmix_dpram #(
    parameter int AW = 8
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr_a_i,
    input  logic          rd_a_i,
    output logic [15:0]   dout_a_o,
    input  logic [AW-1:0] addr_b_i,
    input  logic [15:0]   din_b_i,
    input  logic [1:0]    we_b_i,
    output logic [15:0]   dout_b_o
);

    logic [15:0] mem_q [0:(1<<AW)-1];

    always_ff @(posedge clk_i) begin
        if (rd_a_i) begin
            dout_a_o <= mem_q[addr_a_i];
        end
        dout_b_o <= mem_q[addr_b_i];
        if (we_b_i[0]) begin
            mem_q[addr_b_i][7:0] <= din_b_i[7:0];
        end
        if (we_b_i[1]) begin
            mem_q[addr_b_i][15:8] <= din_b_i[15:8];
        end
    end

endmodule

// File: rtl/jtkunio_colmix.sv
// Kunio colour mixer: fixed-priority layer select, palette lookup and
// blanking-aligned RGB444 output, two pixel-enables from layer pixel to colour.
module jtkunio_colmix
    import jtkunio_colmix_pkg::*;
#(
    parameter string SIMFILE_LO = "pal_lo.bin",
    parameter string SIMFILE_HI = "pal_hi.bin"
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pxl_cen,
    input  logic       LHBL,
    input  logic       LVBL,
    input  logic [5:0] scr_pxl,
    input  logic [6:0] obj_pxl,
    input  logic [4:0] char_pxl,
    input  logic [2:0] gfx_en,
    input  logic [8:0] cpu_addr,
    input  logic       pal_cs,
    input  logic       cpu_wrn,
    input  logic [7:0] cpu_dout,
    output logic [7:0] cpu_din,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       LHBL_dly,
    output logic       LVBL_dly
);

    logic [7:0]  idx_d;
    logic [7:0]  idx_p1_q;
    logic [1:0]  blank_p1_q;
    logic        rden_p2_q;
    logic [15:0] pal_p2;
    logic [15:0] cpu_rd;
    logic        cpu_sel_q;
    logic [3:0]  red_q, green_q, blue_q;
    logic        lhbl_q, lvbl_q;
    logic        cpu_wr;
    logic        char_op, obj_op;

    // Char over obj over scroll; a disabled scroll layer falls back to its backdrop entry.
    always_comb begin
        char_op = gfx_en[0] && (char_pxl[2:0] != 3'd0);
        obj_op  = gfx_en[2] && (obj_pxl[3:0] != 4'd0);
        idx_d   = SCR_BASE;
        if (char_op) begin
            idx_d = CHAR_BASE | {3'b000, char_pxl};
        end else if (obj_op) begin
            idx_d = OBJ_BASE | {1'b0, obj_pxl};
        end else if (gfx_en[1]) begin
            idx_d = SCR_BASE | {2'b00, scr_pxl};
        end
    end

    assign cpu_wr = pal_cs & ~cpu_wrn;

    jtkunio_colmix_dpram #(.AW(8)) u_pal (
        .clk_i    (clk),
        .addr_a_i (idx_p1_q),
        .rd_a_i   (rden_p2_q),
        .dout_a_o (pal_p2),
        .addr_b_i (cpu_addr[7:0]),
        .din_b_i  ({cpu_dout, cpu_dout}),
        .we_b_i   ({cpu_wr & cpu_addr[8], cpu_wr & ~cpu_addr[8]}),
        .dout_b_o (cpu_rd)
    );

    // The video read fires once per pixel, one clk after the index is registered,
    // so a CPU write landing on that same clk is seen only by the next pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_p1_q   <= 8'd0;
            blank_p1_q <= 2'b00;
            rden_p2_q  <= 1'b0;
            red_q      <= 4'd0;
            green_q    <= 4'd0;
            blue_q     <= 4'd0;
            lhbl_q     <= 1'b0;
            lvbl_q     <= 1'b0;
        end else begin
            rden_p2_q <= pxl_cen;
            if (pxl_cen) begin
                idx_p1_q   <= idx_d;
                blank_p1_q <= {LHBL, LVBL};
                lhbl_q     <= blank_p1_q[1];
                lvbl_q     <= blank_p1_q[0];
                if (&blank_p1_q) begin
                    red_q   <= pal_p2[3:0];
                    green_q <= pal_p2[7:4];
                    blue_q  <= pal_p2[11:8];
                end else begin
                    red_q   <= 4'd0;
                    green_q <= 4'd0;
                    blue_q  <= 4'd0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        cpu_sel_q <= cpu_addr[8];
    end

    assign cpu_din  = cpu_sel_q ? cpu_rd[15:8] : cpu_rd[7:0];
    assign red      = red_q;
    assign green    = green_q;
    assign blue     = blue_q;
    assign LHBL_dly = lhbl_q;
    assign LVBL_dly = lvbl_q;

endmodule

// File: tb/tb_jtkunio_colmix.sv
// Randomised bench for jtkunio_colmix against a palette/priority reference model.
module tb_jtkunio_colmix;
    import jtkunio_colmix_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pxl_cen = 1'b0;
    logic       LHBL = 1'b0, LVBL = 1'b0;
    logic [5:0] scr_pxl = '0;
    logic [6:0] obj_pxl = '0;
    logic [4:0] char_pxl = '0;
    logic [2:0] gfx_en = 3'b111;
    logic [8:0] cpu_addr = '0;
    logic       pal_cs = 1'b0;
    logic       cpu_wrn = 1'b1;
    logic [7:0] cpu_dout = '0;
    logic [7:0] cpu_din;
    logic [3:0] red, green, blue;
    logic       LHBL_dly, LVBL_dly;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  lo_m [0:255];
    logic [7:0]  hi_m [0:255];
    logic [13:0] exp_prev;

    jtkunio_colmix dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .scr_pxl(scr_pxl), .obj_pxl(obj_pxl), .char_pxl(char_pxl), .gfx_en(gfx_en),
        .cpu_addr(cpu_addr), .pal_cs(pal_cs), .cpu_wrn(cpu_wrn), .cpu_dout(cpu_dout),
        .cpu_din(cpu_din), .red(red), .green(green), .blue(blue),
        .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", tag, got, want);
        end
    endtask

    function automatic logic [13:0] vid_out();
        return {LHBL_dly, LVBL_dly, red, green, blue};
    endfunction

    // Reference: the pixel's visible colour with the palette as it stands now.
    function automatic logic [13:0] model(input logic [4:0] c, input logic [6:0] o,
                                          input logic [5:0] s, input logic [2:0] en,
                                          input logic h, input logic v);
        int idx;
        if (en[0] && c[2:0] != 0)      idx = int'(c);
        else if (en[2] && o[3:0] != 0) idx = 128 + int'(o);
        else if (en[1])                idx = 64 + int'(s);
        else                           idx = 64;
        if (h && v) return {2'b11, lo_m[idx][3:0], lo_m[idx][7:4], hi_m[idx][3:0]};
        return {h, v, 12'h000};
    endfunction

    task automatic cpu_wr(input logic [8:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_dout = d; pal_cs = 1'b1; cpu_wrn = 1'b0;
        @(negedge clk);
        pal_cs = 1'b0; cpu_wrn = 1'b1;
        if (a[8]) hi_m[a[7:0]] = d;
        else      lo_m[a[7:0]] = d;
    endtask

    task automatic cpu_rd(input logic [8:0] a, input string tag);
        logic [7:0] want;
        want = a[8] ? hi_m[a[7:0]] : lo_m[a[7:0]];
        cpu_addr = a;
        @(negedge clk);
        chk(tag, {24'd0, cpu_din}, {24'd0, want});
    endtask

    // One pixel with its pxl_cen pulse followed by gap-1 idle clocks (gap >= 2).
    // Optionally a CPU write lands on the clk right after the enable edge.
    task automatic pixel(input logic [4:0] c, input logic [6:0] o, input logic [5:0] s,
                         input logic [2:0] en, input logic h, input logic v, input int gap,
                         input bit wr, input logic [8:0] wa, input logic [7:0] wd);
        logic [13:0] shown;
        char_pxl = c; obj_pxl = o; scr_pxl = s; gfx_en = en; LHBL = h; LVBL = v;
        pxl_cen = 1'b1;
        @(negedge clk);
        pxl_cen = 1'b0;
        chk("pix", {18'd0, vid_out()}, {18'd0, exp_prev});
        shown = exp_prev;
        exp_prev = model(c, o, s, en, h, v);
        if (wr) begin
            cpu_addr = wa; cpu_dout = wd; pal_cs = 1'b1; cpu_wrn = 1'b0;
        end
        for (int i = 1; i < gap; i++) begin
            @(negedge clk);
            if (wr && i == 1) begin
                pal_cs = 1'b0; cpu_wrn = 1'b1;
                if (wa[8]) hi_m[wa[7:0]] = wd;
                else       lo_m[wa[7:0]] = wd;
            end
        end
        chk("hold", {18'd0, vid_out()}, {18'd0, shown});
    endtask

    task automatic px(input logic [4:0] c, input logic [6:0] o, input logic [5:0] s,
                      input logic [2:0] en, input logic h, input logic v);
        pixel(c, o, s, en, h, v, 2 + int'($urandom_range(0, 2)), 1'b0, 9'd0, 8'd0);
    endtask

    initial begin
        exp_prev = '0;
        repeat (3) @(negedge clk);
        chk("rst_out", {18'd0, vid_out()}, 32'd0);
        for (int a = 0; a < 512; a++) cpu_wr(9'(a), 8'($urandom));
        chk("rst_hold", {18'd0, vid_out()}, 32'd0);
        rst_n = 1'b1;

        // Priority: char beats obj
        cpu_wr(9'h005, 8'hA3); cpu_wr(9'h105, 8'h07);
        px(5'h05, 7'h13, 6'h2A, 3'b111, 1'b1, 1'b1);
        px(5'h05, 7'h13, 6'h2A, 3'b111, 1'b1, 1'b1);
        px(5'h05, 7'h13, 6'h2A, 3'b111, 1'b1, 1'b1);
        chk("prio_rgb", {20'd0, red, green, blue}, 32'h3A7);

        // Fall-through to scroll colour 0, then obj index 0x81
        cpu_wr(9'h040, 8'h5C); cpu_wr(9'h140, 8'h01);
        px(5'h08, 7'h10, 6'h00, 3'b111, 1'b1, 1'b1);
        px(5'h08, 7'h10, 6'h00, 3'b111, 1'b1, 1'b1);
        chk("scr0_rgb", {20'd0, red, green, blue}, 32'hC51);
        cpu_wr(9'h081, 8'h6D); cpu_wr(9'h181, 8'h0E);
        px(5'h08, 7'h01, 6'h00, 3'b111, 1'b1, 1'b1);
        px(5'h08, 7'h01, 6'h00, 3'b111, 1'b1, 1'b1);
        chk("obj81_rgb", {20'd0, red, green, blue}, 32'hD6E);

        // Char layer disabled
        px(5'h05, 7'h13, 6'h11, 3'b110, 1'b1, 1'b1);
        px(5'h05, 7'h00, 6'h11, 3'b110, 1'b1, 1'b1);
        px(5'h05, 7'h00, 6'h11, 3'b110, 1'b1, 1'b1);

        // Three blanked pixels
        for (int i = 0; i < 3; i++) px(5'h05, 7'h13, 6'h11, 3'b111, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) px(5'h05, 7'h13, 6'h11, 3'b111, 1'b1, 1'b1);

        // CPU access
        cpu_wr(9'h123, 8'h9F);
        cpu_rd(9'h123, "cpu_hi");
        chk("cpu_hi_val", {24'd0, cpu_din}, 32'h9F);
        cpu_rd(9'h023, "cpu_lo");

        // Collision on entry 0x05: old value now, new value next pixel
        cpu_wr(9'h005, 8'hA3);
        pixel(5'h05, 7'h00, 6'h00, 3'b111, 1'b1, 1'b1, 3, 1'b1, 9'h005, 8'h4B);
        pixel(5'h05, 7'h00, 6'h00, 3'b111, 1'b1, 1'b1, 3, 1'b0, 9'h000, 8'h00);
        chk("coll_old", {20'd0, red, green, blue}, 32'h3A7);
        px(5'h05, 7'h00, 6'h00, 3'b111, 1'b1, 1'b1);
        chk("coll_new", {20'd0, red, green, blue}, 32'hB47);

        // Mid-line reset, then black for COLMIX_LAT enables, palette retained
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst", {18'd0, vid_out()}, 32'd0);
        rst_n = 1'b1;
        exp_prev = '0;
        for (int i = 0; i < COLMIX_LAT + 2; i++) px(5'h05, 7'h00, 6'h00, 3'b111, 1'b1, 1'b1);
        chk("rst_keep", {20'd0, red, green, blue}, 32'hB47);

        // Randomised traffic with interleaved CPU accesses
        for (int n = 0; n < 300; n++) begin
            logic [2:0] en;
            en = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            px(5'($urandom), 7'($urandom), 6'($urandom), en,
               $urandom_range(0, 7) != 0, $urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0) cpu_wr(9'($urandom), 8'($urandom));
            if ($urandom_range(0, 15) == 0) cpu_rd(9'($urandom), "cpu_rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
